// File: rtl/fetch_port_arbiter.sv
// fetch_port_arbiter: shares one synchronous object-memory read port between
// two fetch requesters. Each transaction runs IDLE -> ISSUE -> WAIT -> RESP,
// or IDLE -> RESP directly when the address is beyond the populated objects.
// Optional build macro ARB_FIXED_PRIO_EN: requester 0 always wins a tie and
// the round-robin pointer is removed; otherwise ties alternate round-robin.
module fetch_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_OBJ  = 36,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        gnt,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // The wait counter loads READ_LAT-1 and the capture happens when it hits zero.
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] OBJ_LIMIT = ADDR_W'(NUM_OBJ);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pick1;
  logic [ADDR_W-1:0] sel_addr;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 only wins when requester 0 is not asking.
  assign pick1 = ~req[0];
`else
  // last_q remembers which requester was served last; reset to 1 so that
  // requester 0 takes the very first tie.
  logic last_q, last_d;

  assign pick1 = (req == 2'b10) || ((req == 2'b11) && (last_q == 1'b0));

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end
`endif

  assign sel_addr = pick1 ? req_addr1 : req_addr0;

  // Transaction state and captured response fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate and range-check in IDLE, sequence the read after.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d  = pick1 ? 2'b10 : 2'b01;
          addr_d = sel_addr;
          data_d = '0;
          err_d  = (sel_addr >= OBJ_LIMIT);
          state_d = (sel_addr >= OBJ_LIMIT) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        gnt_d   = 2'b00;
`ifndef ARB_FIXED_PRIO_EN
        last_d  = gnt_q[1];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign rsp_valid = (state_q == RESP) ? gnt_q : 2'b00;
  assign rsp_data  = data_q;
  assign rsp_err   = (state_q == RESP) && err_q;
  assign mem_en    = (state_q == ISSUE);
  assign mem_addr  = (state_q == ISSUE) ? addr_q : '0;
  assign busy      = (state_q != IDLE);

endmodule
